// File: rtl/cache_ctrl.sv
// Blocking write-back controller for a direct-mapped cache array.
// Sequences tag compare, hit access, dirty write-back and line refill.
module cache_ctrl #(
    parameter int ADDR_BITS        = 32,
    parameter int WORD_BITS        = 32,
    parameter int TAG_BITS         = 22,
    parameter int WORD_BYTES_WIDTH = 2,
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int LINE_INDEX_WIDTH = 6,
    parameter int CNT_BITS         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_ack,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic [WORD_BITS-1:0] cache_din,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_din,
    input  logic [WORD_BITS-1:0] mem_dout,
    input  logic                 mem_ack,
    output logic [CNT_BITS-1:0]  hit_cnt,
    output logic [CNT_BITS-1:0]  miss_cnt
);

    localparam int OFF_BITS = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
    localparam int TAG_LO   = OFF_BITS + LINE_INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WBACK,
        FILL
    } state_t;

    state_t state, state_nx;

    logic [ADDR_BITS-1:0]        req_addr;
    logic                        req_we;
    logic [WORD_BITS-1:0]        req_din;
    logic [TAG_BITS-1:0]         victim_tag;
    logic [LINE_WORDS_WIDTH-1:0] word_cnt;
    logic                        refilled;

    logic [TAG_BITS-1:0]         req_tag;
    logic [LINE_INDEX_WIDTH-1:0] req_idx;
    logic [ADDR_BITS-1:0]        wb_addr;
    logic [ADDR_BITS-1:0]        fill_addr;
    logic                        last_word;

    assign req_tag   = req_addr[ADDR_BITS-1:TAG_LO];
    assign req_idx   = req_addr[TAG_LO-1:OFF_BITS];
    assign wb_addr   = {victim_tag, req_idx, word_cnt,
                        {WORD_BYTES_WIDTH{1'b0}}};
    assign fill_addr = {req_tag, req_idx, word_cnt,
                        {WORD_BYTES_WIDTH{1'b0}}};
    assign last_word = &word_cnt;

    assign cache_invalid = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_din    <= '0;
            victim_tag <= '0;
            word_cnt   <= '0;
            refilled   <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr <= cpu_addr;
                        req_we   <= cpu_we;
                        req_din  <= cpu_din;
                        refilled <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (cache_hit) begin
                        // the re-compare after a refill is not a hit
                        if (!refilled && hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + CNT_BITS'(1);
                        end
                    end else begin
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + CNT_BITS'(1);
                        end
                        victim_tag <= cache_tag;
                        word_cnt   <= '0;
                    end
                end
                WBACK, FILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + LINE_WORDS_WIDTH'(1);
                        if (state == FILL && last_word) begin
                            refilled <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        cpu_dout    = '0;
        cpu_ack     = 1'b0;
        cache_addr  = '0;
        cache_din   = '0;
        cache_store = 1'b0;
        cache_edit  = 1'b0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                cache_addr = req_addr;
                if (cache_hit) begin
                    cpu_ack  = 1'b1;
                    state_nx = IDLE;
                    if (req_we) begin
                        cache_edit = 1'b1;
                        cache_din  = req_din;
                    end else begin
                        cpu_dout = cache_dout;
                    end
                end else if (cache_valid && cache_dirty) begin
                    state_nx = WBACK;
                end else begin
                    state_nx = FILL;
                end
            end
            WBACK: begin
                cache_addr = wb_addr;
                mem_addr   = wb_addr;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_din    = cache_dout;
                if (mem_ack && last_word) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                cache_addr = fill_addr;
                mem_addr   = fill_addr;
                mem_cs     = 1'b1;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_dout;
                    if (last_word) begin
                        state_nx = COMPARE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural array and memory around the DUT,
// plus a line-level cache model that predicts data, latency and traffic.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_ack;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_store, cache_edit, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic        mem_cs, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [15:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .cache_addr(cache_addr), .cache_din(cache_din),
        .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // initial memory image: fixed lines for the directed tests
    function automatic logic [31:0] pat(input int w);
        int a;
        a = w * 4;
        if (a >= 'h100 && a < 'h110) return 32'hA0 + 32'((a - 'h100) / 4);
        if (a >= 'h4100 && a < 'h4110) return 32'hB0 + 32'((a - 'h4100) / 4);
        if (a >= 'h200 && a < 'h210) return 32'hC0 + 32'((a - 'h200) / 4);
        return 32'h5000_0000 + 32'(w);
    endfunction

    // cache array
    logic        a_valid [64];
    logic        a_dirty [64];
    logic [21:0] a_tag   [64];
    logic [31:0] a_data  [256];
    logic [5:0]  c_idx;
    logic [7:0]  c_wi;
    assign c_idx       = cache_addr[9:4];
    assign c_wi        = cache_addr[9:2];
    assign cache_valid = a_valid[c_idx];
    assign cache_dirty = a_dirty[c_idx];
    assign cache_tag   = a_tag[c_idx];
    assign cache_hit   = a_valid[c_idx] && (a_tag[c_idx] == cache_addr[31:10]);
    assign cache_dout  = a_data[c_wi];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                a_valid[i] <= 1'b0;
                a_dirty[i] <= 1'b0;
            end
        end else if (cache_store) begin
            a_data[c_wi]  <= cache_din;
            a_valid[c_idx] <= 1'b1;
            a_dirty[c_idx] <= 1'b0;
            a_tag[c_idx]   <= cache_addr[31:10];
        end else if (cache_edit) begin
            a_data[c_wi]  <= cache_din;
            a_dirty[c_idx] <= 1'b1;
        end
    end

    // main memory with programmable ack latency
    logic [31:0] emem [8192];
    logic        ewr  [8192];
    logic        mem_clr;
    int          lat = 1;
    int          wcnt = 0;
    logic [12:0] m_w;
    assign m_w      = mem_addr[14:2];
    assign mem_ack  = mem_cs && (wcnt == lat - 1);
    assign mem_dout = (mem_ack && !mem_we) ?
                      (ewr[m_w] ? emem[m_w] : pat(int'(m_w))) : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) ewr[i] <= 1'b0;
        end else if (mem_ack && mem_we) begin
            emem[m_w] <= mem_din;
            ewr[m_w]  <= 1'b1;
        end
        if (rst || !mem_cs || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // reference model
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         exp_q [$];
    logic        m_valid [64];
    logic        m_dirty [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_line  [64][4];
    logic [31:0] m_mem   [8192];
    int          m_hits, m_miss;
    int          total, bad, edits;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic predict(input logic we, input logic [31:0] a,
                           input logic [31:0] d, output int cyc,
                           output logic [31:0] rd);
        int idx, w, lb, vb;
        logic [21:0] t;
        logic [31:0] vaddr;
        idx = int'(a[9:4]);
        w   = int'(a[3:2]);
        t   = a[31:10];
        lb  = int'(a[14:4]) * 4;
        if (m_valid[idx] && m_tag[idx] == t) begin
            if (m_hits < 65535) m_hits++;
            cyc = 1;
        end else begin
            if (m_miss < 65535) m_miss++;
            cyc = 2 + 4 * lat;
            if (m_valid[idx] && m_dirty[idx]) begin
                cyc += 4 * lat;
                vaddr = {m_tag[idx], 6'(idx), 4'b0};
                vb = int'(vaddr[14:2]);
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back({1'b1, vaddr + 32'(4 * k), m_line[idx][k]});
                    m_mem[vb + k] = m_line[idx][k];
                end
            end
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({1'b0, {a[31:4], 4'b0} + 32'(4 * k), 32'h0});
                m_line[idx][k] = m_mem[lb + k];
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = t;
        end
        if (we) begin
            m_line[idx][w] = d;
            m_dirty[idx]   = 1'b1;
        end
        rd = m_line[idx][w];
    endtask

    task automatic txn(input logic we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] got,
                       output int c);
        int el;
        logic [31:0] ed;
        bit seen;
        predict(we, a, d, el, ed);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        seen = 0; c = 0; got = '0;
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            cpu_req = 1'b0;
            if (cpu_ack) begin
                seen = 1;
                got  = cpu_dout;
            end
        end
        chk("ack_seen", 64'(seen), 1);
        chk("latency", 64'(c), 64'(el));
        if (!we) chk("rdata", got, ed);
        @(negedge clk);
        chk("ack_pulse", cpu_ack, 0);
        chk("hit_cnt", hit_cnt, 64'(m_hits));
        chk("miss_cnt", miss_cnt, 64'(m_miss));
        chk("mem_q_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ack"}, cpu_ack, 0);
        chk({nm, "_dout"}, cpu_dout, 0);
        chk({nm, "_caddr"}, cache_addr, 0);
        chk({nm, "_cdin"}, cache_din, 0);
        chk({nm, "_strb"}, {cache_store, cache_edit, cache_invalid}, 0);
        chk({nm, "_mem"}, {mem_cs, mem_we, mem_addr, mem_din}, 0);
        chk({nm, "_cnt"}, {hit_cnt, miss_cnt}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int c, e0, acks, accepts, ack_at, el;
        logic [31:0] pend, ed, ad;
        total = 0; bad = 0; edits = 0;
        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        for (int i = 0; i < 8192; i++) m_mem[i] = pat(i);
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0; m_miss = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0; mem_clr = 1'b0;

        fork
            begin
                logic hold_v, hold_we;
                logic [31:0] hold_a, hold_d;
                op_t op;
                hold_v = 1'b0; hold_we = 1'b0; hold_a = '0; hold_d = '0;
                forever begin
                    @(negedge clk);
                    chk("store_edit_excl", 64'(cache_store && cache_edit), 0);
                    chk("cs_in_compare", 64'(mem_cs && cpu_ack), 0);
                    if (cache_edit) edits++;
                    if (hold_v) begin
                        chk("hold_cs", mem_cs, 1);
                        chk("hold_we", mem_we, hold_we);
                        chk("hold_addr", mem_addr, hold_a);
                        chk("hold_din", mem_din, hold_d);
                    end
                    hold_v = mem_cs && !mem_ack;
                    hold_we = mem_we; hold_a = mem_addr; hold_d = mem_din;
                    if (mem_cs && mem_ack) begin
                        if (exp_q.size() == 0) begin
                            chk("mem_unexpected", 1, 0);
                        end else begin
                            op = exp_q.pop_front();
                            chk("mem_we", mem_we, op.we);
                            chk("mem_addr", mem_addr, op.addr);
                            if (op.we) chk("mem_din", mem_din, op.data);
                        end
                    end
                end
            end
        join_none

        // clean miss then hit
        txn(1'b0, 32'h100, 0, got, c);
        chk("lit_rd100", got, 32'hA0);
        chk("lit_lat_clean", 64'(c), 6);
        chk("lit_miss1", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
        txn(1'b0, 32'h108, 0, got, c);
        chk("lit_rd108", got, 32'hA2);
        chk("lit_hit1", hit_cnt, 1);

        // write hit, then dirty eviction
        e0 = edits;
        txn(1'b1, 32'h104, 32'hDEAD_BEEF, got, c);
        chk("lit_edit_pulse", 64'(edits - e0), 1);
        chk("lit_lat_whit", 64'(c), 1);
        txn(1'b0, 32'h4104, 0, got, c);
        chk("lit_rd4104", got, 32'hB1);
        chk("lit_lat_dirty", 64'(c), 10);
        chk("lit_wb104", emem[13'h41], 32'hDEAD_BEEF);

        // slow memory
        lat = 3;
        txn(1'b0, 32'h200, 0, got, c);
        chk("lit_rd200", got, 32'hC0);
        chk("lit_lat_slow", 64'(c), 14);
        lat = 1;

        // write-allocate miss
        e0 = edits;
        txn(1'b1, 32'h300, 32'h1234_5678, got, c);
        chk("lit_lat_wmiss", 64'(c), 6);
        chk("lit_wmiss_edit", 64'(edits - e0), 1);
        txn(1'b0, 32'h300, 0, got, c);
        chk("lit_rd300", got, 32'h1234_5678);

        // reset during the second fill word
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        exp_q.push_back({1'b0, 32'h100, 32'h0});
        exp_q.push_back({1'b0, 32'h104, 32'h0});
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0; m_miss = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {cpu_ack, mem_cs, cache_store}, 0);
        end
        chk("post_rst_q", 64'(exp_q.size()), 0);
        txn(1'b0, 32'h100, 0, got, c);
        chk("lit_rerd100", got, 32'hA0);
        chk("lit_rerd_cnt", {hit_cnt, miss_cnt}, {16'd0, 16'd1});

        // cpu_req held high with changing addresses
        acks = 0; accepts = 0; ack_at = -1; pend = '0;
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int t = 0; t < 21; t++) begin
            if (t > 0) @(negedge clk);
            chk("cont_ack", cpu_ack, 64'(t == ack_at));
            if (cpu_ack) acks++;
            if (t == ack_at) chk("cont_dout", cpu_dout, pend);
            ad = ((t / 3) % 2 == 1) ? 32'h108 : 32'h100;
            cpu_addr = ad;
            if (t > ack_at) begin
                if (t == 20) begin
                    cpu_req = 1'b0;
                end else begin
                    predict(1'b0, ad, 0, el, ed);
                    ack_at = t + el;
                    pend = ed;
                    accepts++;
                end
            end
        end
        @(negedge clk);
        chk("cont_idle", cpu_ack, 0);
        chk("cont_acks", 64'(acks), 64'(accepts));
        chk("lit_cont_acks", 64'(acks), 10);
        chk("cont_hits", hit_cnt, 64'(m_hits));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Blocking write-back controller that sequences one direct-mapped cache array between a single CPU requester and main memory. It performs the tag check, hit read and write, dirty-line write-back and line refill. It drives the array's store, edit and address controls and consumes its hit, valid, dirty, tag and dout outputs. The array sits combinationally next to it; memory sits behind a cs/we/ack handshake.

Parameters:
ADDR_BITS, 32, byte address width
WORD_BITS, 32, data word width
TAG_BITS, 22, tag width = ADDR_BITS - LINE_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
WORD_BYTES_WIDTH, 2, log2 bytes per word
LINE_WORDS_WIDTH, 2, log2 words per line (line = 4 words)
LINE_INDEX_WIDTH, 6, log2 line count (64 lines)
CNT_BITS, 16, width of hit/miss statistic counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  request valid, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_BITS  byte address
cpu_din  in  WORD_BITS  write data
cpu_dout  out  WORD_BITS  read data, valid while cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse
cache_addr  out  ADDR_BITS  array address
cache_din  out  WORD_BITS  array write data
cache_store  out  1  array fill write (sets valid, clears dirty, loads tag)
cache_edit  out  1  array CPU write (sets dirty)
cache_invalid  out  1  array invalidate; tied 0 in this revision
cache_hit  in  1  array tag match and valid
cache_valid  in  1  indexed line valid
cache_dirty  in  1  indexed line dirty
cache_tag  in  TAG_BITS  indexed line tag
cache_dout  in  WORD_BITS  array read word
mem_cs  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_BITS  memory word address, low WORD_BYTES_WIDTH bits = 0
mem_din  out  WORD_BITS  memory write data
mem_dout  in  WORD_BITS  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, may be asserted in the same cycle as mem_cs
hit_cnt  out  CNT_BITS  saturating count of hits on first compare
miss_cnt  out  CNT_BITS  saturating count of misses

Behaviour:
- States: IDLE, COMPARE, WBACK, FILL. Registers: req_addr, req_we, req_din, victim_tag, word_cnt (LINE_WORDS_WIDTH bits), refilled flag.
- Reset (synchronous, any state): state = IDLE, word_cnt = 0, hit_cnt = 0, miss_cnt = 0. All outputs are 0 after reset, including cpu_ack, mem_cs, cache_store and cache_edit. An in-flight memory transaction is abandoned and a late mem_ack is ignored in IDLE.
- IDLE: if cpu_req, latch addr, we and din; clear refilled; go to COMPARE. No array or memory strobes are driven. cpu_req is ignored in every other state.
- COMPARE: cache_addr = req_addr.
  - Hit, read: cpu_dout = cache_dout, cpu_ack = 1, go to IDLE.
  - Hit, write: cache_edit = 1, cache_din = req_din, cpu_ack = 1, go to IDLE.
  - hit_cnt increments only if refilled = 0.
  - Miss: miss_cnt increments and victim_tag is latched from cache_tag. Go to WBACK if cache_valid and cache_dirty, otherwise go to FILL. word_cnt = 0 in both cases.
- WBACK: the address is {victim_tag, req index, word_cnt, 0s} and drives both cache_addr and mem_addr. mem_cs = 1, mem_we = 1, mem_din = cache_dout.
  - mem_cs, mem_addr and mem_din are held stable until mem_ack.
  - On mem_ack: word_cnt increments. After the last word, word_cnt wraps to 0 and the state goes to FILL.
- FILL: the address is {req tag, req index, word_cnt, 0s}. mem_cs = 1, mem_we = 0.
  - On mem_ack: cache_store = 1 with cache_addr = the same address and cache_din = mem_dout, then word_cnt increments.
  - After the last word: set refilled, go to COMPARE. The re-compare hits and completes the request.
- Write miss is write-allocate: fill first, then the edit in COMPARE.
- Latency with a zero-wait memory (mem_ack in the same cycle as mem_cs), counting from the cpu_req cycle in IDLE as cycle 0:
  - Hit: ack at cycle 1.
  - Clean miss: ack at cycle 6.
  - Dirty miss: ack at cycle 10.
- Counters saturate at all-ones; they do not wrap.
- cache_store and cache_edit are never asserted in the same cycle. mem_cs is never asserted in IDLE or COMPARE.

Test Plan:
- After reset, read 0x0000_0100 with memory words 0xA0..0xA3 at 0x100..0x10C -> FILL issues 4 mem reads at 0x100, 0x104, 0x108, 0x10C; cpu_ack at cycle 6 with cpu_dout = 0xA0; miss_cnt = 1, hit_cnt = 0.
- Then read 0x0000_0108 -> cpu_ack at cycle 1, cpu_dout = 0xA2, no mem_cs, hit_cnt = 1.
- Write 0xDEAD_BEEF to 0x104 -> cache_edit pulses for one cycle and cpu_ack is asserted at cycle 1. Then read 0x0000_4104 (same index, different tag) -> 4 mem writes to 0x100..0x10C with data 0xA0, 0xDEADBEEF, 0xA2, 0xA3, then 4 reads from 0x4100..0x410C, then cpu_ack.
- Memory with 3-cycle ack latency -> mem_cs and mem_addr are held stable for 3 cycles per word; total clean-miss latency = 1 + 4×3 + 1 cycles.
- Assert rst for one cycle during the second FILL word -> the next cycle is IDLE, all outputs are 0 and both counters are 0. A following read of the same address misses again and refills correctly.
- Drive cpu_req high continuously with alternating addresses -> each request is accepted only in IDLE and there is exactly one cpu_ack per accepted request.
